// File: rtl/mul8_share_arb_if.sv
// mul8_share_arb_if: request/response handshake bundle for mul8_share_arb.
// req0/req1: valid, ready, a, b; rsp0/rsp1: valid, ready; rsp_data, busy.
interface mul8_share_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [15:0] rsp_data;
  logic        busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp_data, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp_data, busy
  );
endinterface

// File: rtl/mul8_share_arb.sv
// mul8_share_arb: round-robin share of one 8x8 multiplier (multi_8).
// Ports: clk, rst_n (sync, active-low), bus (slave modport of
// mul8_share_arb_if). Macro MUL8_SHARE_ARB_STATS_EN adds
// gnt0_cnt/gnt1_cnt saturating accept counters.
module multi_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  assign p = 16'(a) * 16'(b);
endmodule

module mul8_share_arb #(
  parameter int unsigned CALC_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  mul8_share_arb_if.slave bus
`ifdef MUL8_SHARE_ARB_STATS_EN
  ,
  output logic [15:0] gnt0_cnt,
  output logic [15:0] gnt1_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES - 1);

  state_t      state;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [3:0]  cnt;
  logic        owner;
  logic        last_grant;
  logic [15:0] rsp_q;
  logic        v0_q;
  logic        v1_q;
  logic        busy_q;
  logic [15:0] prod;
  logic        gnt0;
  logic        gnt1;

  // multiplier sees only the op registers
  multi_8 u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // tie goes to the requester that did not win last time
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      priority case (1'b1)
        bus.req0_valid && bus.req1_valid: begin
          gnt0 = last_grant;
          gnt1 = ~last_grant;
        end
        bus.req0_valid: gnt0 = 1'b1;
        bus.req1_valid: gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_q      <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_a       <= gnt1 ? bus.req1_a : bus.req0_a;
            op_b       <= gnt1 ? bus.req1_b : bus.req0_b;
            owner      <= gnt1;
            last_grant <= gnt1;
            cnt        <= CNT_INIT;
            state      <= CALC;
            busy_q     <= 1'b1;
          end
        end
        CALC: begin
          if (cnt == 4'd0) begin
            rsp_q <= prod;
            state <= RESP;
            v0_q  <= ~owner;
            v1_q  <= owner;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // only the owner's ready releases the product
          if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp0_valid = v0_q;
  assign bus.rsp1_valid = v1_q;
  assign bus.rsp_data   = rsp_q;
  assign bus.busy       = busy_q;

`ifdef MUL8_SHARE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      if (gnt0 && gnt0_cnt != 16'hffff)
        gnt0_cnt <= gnt0_cnt + 16'd1;
      if (gnt1 && gnt1_cnt != 16'hffff)
        gnt1_cnt <= gnt1_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul8_share_arb.sv
// tb_mul8_share_arb: directed plus random checks of mul8_share_arb
// against a transaction-level model (round-robin, a*b, fixed latency).
module tb_mul8_share_arb;
  localparam int unsigned C1 = 1;
  localparam int unsigned C4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        m_last = 1'b1;
  int unsigned m_g0 = 0;
  int unsigned m_g1 = 0;

  mul8_share_arb_if bus ();
  mul8_share_arb_if bus4 ();

`ifdef MUL8_SHARE_ARB_STATS_EN
  logic [15:0] g0, g1, g0_4, g1_4;
`endif

  mul8_share_arb #(.CALC_CYCLES(C1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MUL8_SHARE_ARB_STATS_EN
    ,
    .gnt0_cnt (g0),
    .gnt1_cnt (g1)
`endif
  );

  mul8_share_arb #(.CALC_CYCLES(C4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
`ifdef MUL8_SHARE_ARB_STATS_EN
    ,
    .gnt0_cnt (g0_4),
    .gnt1_cnt (g1_4)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input logic v0, input logic v1,
                                input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  task automatic model_reset();
    m_last = 1'b1;
    m_g0 = 0;
    m_g1 = 0;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    bus4.req0_valid = 0; bus4.req0_a = 0; bus4.req0_b = 0;
    bus4.req1_valid = 0; bus4.req1_a = 0; bus4.req1_b = 0;
    bus4.rsp0_ready = 0; bus4.rsp1_ready = 0;
  endtask

  // one full transaction on the CALC_CYCLES=1 instance, starting in IDLE
  task automatic txn(input logic v0, input logic v1,
                     input logic [7:0] a0, input logic [7:0] b0,
                     input logic [7:0] a1, input logic [7:0] b1,
                     input int hold);
    logic        w;
    logic [15:0] expd;
    int          n;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    #1;
    w = pick(v0, v1, m_last);
    check("req0_ready", 32'(bus.req0_ready), 32'(v0 && !w));
    check("req1_ready", 32'(bus.req1_ready), 32'(v1 && w));
    expd = w ? 16'(a1) * 16'(b1) : 16'(a0) * 16'(b0);
    tick();
    m_last = w;
    if (w) m_g1++;
    else m_g0++;
    bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
    bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
    #1;
    n = 1;
    while (!(w ? bus.rsp1_valid : bus.rsp0_valid) && n < 40) begin
      check("calc_ready", {bus.req0_ready, bus.req1_ready}, 0);
      check("calc_busy", 32'(bus.busy), 1);
      tick();
      n++;
    end
    check("latency", n, C1 + 1);
    check("rsp_data", 32'(bus.rsp_data), 32'(expd));
    check("rsp_other",
          32'(w ? bus.rsp0_valid : bus.rsp1_valid), 0);
    check("resp_ready", {bus.req0_ready, bus.req1_ready}, 0);
    // non-owner ready high and non-owner request pending: both ignored
    bus.rsp0_ready = w;
    bus.rsp1_ready = !w;
    if (w) bus.req0_valid = 1;
    else bus.req1_valid = 1;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(w ? bus.rsp1_valid : bus.rsp0_valid), 1);
      check("hold_data", 32'(bus.rsp_data), 32'(expd));
      check("hold_ready", {bus.req0_ready, bus.req1_ready}, 0);
    end
    bus.rsp0_ready = !w;
    bus.rsp1_ready = w;
    tick();
    check("done_busy", 32'(bus.busy), 0);
    check("done_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    bus.rsp0_ready = 0;
    bus.rsp1_ready = 0;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] v;
    int         n;
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    model_reset();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    check("rst_data", 32'(bus.rsp_data), 0);
    check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
    check("rst4_busy", 32'(bus4.busy), 0);
`ifdef MUL8_SHARE_ARB_STATS_EN
    check("rst_gnt0", 32'(g0), 0);
    check("rst_gnt1", 32'(g1), 0);
`endif

    // single request from requester 0
    txn(1, 0, 100, 100, 0, 0, 0);

    // tie from reset: 0 then 1 then 0 then 1
    rst_n = 0;
    tick();
    rst_n = 1;
    model_reset();
    txn(1, 1, 3, 5, 9, 9, 0);
    txn(1, 1, 3, 5, 9, 9, 1);
    txn(1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
    txn(1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2);

    // max operands, long hold on requester 1
    txn(0, 1, 0, 0, 255, 255, 5);
    clear_inputs();

    // valid pulse that never meets a clock edge latches nothing
    bus.req1_valid = 1; bus.req1_a = 33; bus.req1_b = 3;
    #1;
    check("pulse_ready", 32'(bus.req1_ready), 1);
    bus.req1_valid = 0;
    tick();
    check("pulse_busy", 32'(bus.busy), 0);

    // reset while in CALC
    bus.req0_valid = 1; bus.req0_a = 1; bus.req0_b = 255;
    #1;
    check("r4_ready", 32'(bus.req0_ready), 1);
    tick();
    bus.req0_valid = 0;
    rst_n = 0;
    tick();
    check("r4_busy", 32'(bus.busy), 0);
    check("r4_valid", 32'(bus.rsp0_valid), 0);
    check("r4_data", 32'(bus.rsp_data), 0);
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r4_quiet", {bus.rsp0_valid, bus.rsp1_valid, bus.busy}, 0);
    end
    txn(1, 0, 17, 17, 0, 0, 1);
    clear_inputs();

    // four-cycle instance: latency and ready gating in CALC
    bus4.req1_valid = 1; bus4.req1_a = 20; bus4.req1_b = 50;
    #1;
    check("c4_req1_ready", 32'(bus4.req1_ready), 1);
    tick();
    bus4.req1_valid = 0;
    bus4.req0_valid = 1; bus4.req0_a = 7; bus4.req0_b = 7;
    #1;
    n = 1;
    while (!bus4.rsp1_valid && n < 40) begin
      check("c4_req0_ready", 32'(bus4.req0_ready), 0);
      tick();
      n++;
    end
    check("c4_latency", n, C4 + 1);
    check("c4_data", 32'(bus4.rsp_data), 1000);
    check("c4_rsp0", 32'(bus4.rsp0_valid), 0);
    bus4.rsp1_ready = 1;
    tick();
    bus4.rsp1_ready = 0;
    check("c4_done_busy", 32'(bus4.busy), 0);
    check("c4_next_ready", 32'(bus4.req0_ready), 1);
`ifdef MUL8_SHARE_ARB_STATS_EN
    check("c4_gnt1", 32'(g1_4), 1);
    check("c4_gnt0", 32'(g0_4), 0);
`endif
    // reset with the counter still running
    tick();
    bus4.req0_valid = 0;
    tick();
    tick();
    check("c4_mid_busy", 32'(bus4.busy), 1);
    rst_n = 0;
    tick();
    check("c4_r_busy", 32'(bus4.busy), 0);
    check("c4_r_valid", {bus4.rsp0_valid, bus4.rsp1_valid}, 0);
    check("c4_r_data", 32'(bus4.rsp_data), 0);
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("c4_quiet", {bus4.rsp0_valid, bus4.rsp1_valid}, 0);
    end

    // grant counting: three for 0, two for 1
    txn(1, 0, 12, 20, 0, 0, 0);
    txn(0, 1, 0, 0, 8'($urandom), 8'($urandom), 1);
    txn(1, 0, 8'($urandom), 8'($urandom), 0, 0, 0);
    txn(0, 1, 0, 0, 0, 77, 0);
    txn(1, 0, 255, 1, 0, 0, 0);
`ifdef MUL8_SHARE_ARB_STATS_EN
    check("gnt0_cnt", 32'(g0), 3);
    check("gnt1_cnt", 32'(g1), 2);
`endif

    // random traffic
    for (int k = 0; k < 60; k++) begin
      v = 2'($urandom_range(1, 3));
      txn(v[0], v[1], 8'($urandom), 8'($urandom),
          8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end
    clear_inputs();
    tick();
`ifdef MUL8_SHARE_ARB_STATS_EN
    check("gnt0_final", 32'(g0), 32'(m_g0));
    check("gnt1_final", 32'(g1), 32'(m_g1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
